// File: rtl/irq_pio_pkg.sv
// irq_pio_pkg: register map constants and helpers shared by the irq_pio_ctrl block.
// The debounce counters are built only when IRQ_PIO_DEBOUNCE_EN is defined.
package irq_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;

    // Smallest r with 2**r >= v; used to size the debounce counter.
    function automatic int unsigned clog2_fn(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_pio_debounce.sv
// irq_pio_debounce: one input channel, SYNC_STAGES-deep synchroniser followed by an
// optional debounce filter (present only when IRQ_PIO_DEBOUNCE_EN is defined).
module irq_pio_debounce
    import irq_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // Synchroniser shift chain; the oldest sample is the synchronised level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef IRQ_PIO_DEBOUNCE_EN
    localparam int unsigned CntW = clog2_fn(DEBOUNCE_CYCLES) + 1;

    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
`else
    assign stable_o = sync;
`endif

endmodule

// File: rtl/irq_pio_ctrl.sv
// irq_pio_ctrl: Avalon-MM input PIO with per-channel sync/debounce, rising/falling
// edge capture (write-1-to-clear) and a maskable registered level interrupt.
// Define IRQ_PIO_DEBOUNCE_EN to build the per-channel debounce counters.
module irq_pio_ctrl
    import irq_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d_q;
    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;

    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        irq_pio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .d_i     (in_port[i]),
            .stable_o(stable[i])
        );
    end

    assign wr_en = chipselect & ~write_n;
    assign wdata = WIDTH'(writedata);
    assign rise  = stable & ~stable_d_q & rise_en_q;
    assign fall  = ~stable & stable_d_q & fall_en_q;

    // Register writes, edge capture (set beats clear), read mux and irq next-state.
    always_comb begin
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        edgecap_d  = edgecap_q;
        if (wr_en) begin
            case (address)
                ADDR_RISE_EN:  rise_en_d  = wdata;
                ADDR_IRQ_MASK: irq_mask_d = wdata;
                ADDR_EDGECAP:  edgecap_d  = edgecap_q & ~wdata;
                ADDR_FALL_EN:  fall_en_d  = wdata;
                default:       ;
            endcase
        end
        edgecap_d = edgecap_d | rise | fall;

        case (address)
            ADDR_DATA:     readdata_d = 32'(stable);
            ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
            ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGECAP:  readdata_d = 32'(edgecap_q);
            ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
            default:       readdata_d = 32'd0;
        endcase

        irq_d = |(edgecap_q & irq_mask_q);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_mask_q <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            stable_d_q <= stable;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            irq_mask_q <= irq_mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_irq_pio_ctrl.sv
// tb_irq_pio_ctrl: directed, table-driven bench for irq_pio_ctrl (WIDTH=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Debounce glitch checks are built only with IRQ_PIO_DEBOUNCE_EN.
module tb_irq_pio_ctrl;
    import irq_pio_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;
    localparam int unsigned D = 4;
`ifdef IRQ_PIO_DEBOUNCE_EN
    localparam int LAT = D;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] in_port;
    logic [31:0]  readdata;
    logic         irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    irq_pio_ctrl #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        address = a;
        tick();
        check(nm, readdata, exp);
    endtask

    task automatic settle();
        repeat (S + LAT + 4) tick();
    endtask

    initial begin
        vecs[0]  = '{1'b1, ADDR_RISE_EN,  32'h0000_00A5, 32'h0};
        vecs[1]  = '{1'b0, ADDR_RISE_EN,  32'h0,         32'h0000_00A5};
        vecs[2]  = '{1'b1, ADDR_IRQ_MASK, 32'h0000_003C, 32'h0};
        vecs[3]  = '{1'b0, ADDR_IRQ_MASK, 32'h0,         32'h0000_003C};
        vecs[4]  = '{1'b1, ADDR_FALL_EN,  32'h0000_005A, 32'h0};
        vecs[5]  = '{1'b0, ADDR_FALL_EN,  32'h0,         32'h0000_005A};
        vecs[6]  = '{1'b1, ADDR_DATA,     32'h0000_0000, 32'h0};
        vecs[7]  = '{1'b0, ADDR_DATA,     32'h0,         32'h0000_00FF};
        vecs[8]  = '{1'b1, 3'd5,          32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, 3'd5,          32'h0,         32'h0};
        vecs[10] = '{1'b0, 3'd6,          32'h0,         32'h0};
        vecs[11] = '{1'b0, 3'd7,          32'h0,         32'h0};
        vecs[12] = '{1'b1, ADDR_RISE_EN,  32'hFFFF_FF01, 32'h0};
        vecs[13] = '{1'b0, ADDR_RISE_EN,  32'h0,         32'h0000_0001};
        vecs[14] = '{1'b1, ADDR_FALL_EN,  32'h0000_0000, 32'h0};
        vecs[15] = '{1'b0, ADDR_EDGECAP,  32'h0,         32'h0};

        reset      = 1'b1;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;

        // Reset values of every address.
        repeat (3) tick();
        check("irq_in_reset", 32'(irq), 32'h0);
        check("rd_in_reset", readdata, 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'h0, "reset_reg");
        end
        check("irq_after_reset", 32'(irq), 32'h0);

        // Input held high through reset: DATA stays 0 until the latency elapses.
        reset   = 1'b1;
        in_port = 8'hFF;
        address = ADDR_DATA;
        repeat (3) tick();
        check("data_in_reset_ff", readdata, 32'h0);
        reset = 1'b0;
        for (int j = 0; j <= S + LAT; j++) begin
            tick();
            check("data_reset_latency", readdata, (j >= S + LAT) ? 32'hFF : 32'h0);
        end
        settle();
        rd(ADDR_EDGECAP, 32'h0, "no_edge_rise_en0");

        // Register read/write table.
        for (int k = 0; k < 16; k++) begin
            if (vecs[k].wr) begin
                wr(vecs[k].addr, vecs[k].data);
            end else begin
                rd(vecs[k].addr, vecs[k].exp, $sformatf("vec%0d", k));
            end
        end
        wr(ADDR_RISE_EN, 32'h0);
        wr(ADDR_IRQ_MASK, 32'h0);
        in_port = 8'h00;
        settle();
        rd(ADDR_EDGECAP, 32'h0, "no_edge_fall_en0");

        // Rising edge on bit 0: exact irq latency, then W1C.
        wr(ADDR_RISE_EN, 32'h01);
        wr(ADDR_IRQ_MASK, 32'h01);
        in_port[0] = 1'b1;
        for (int j = 0; j <= S + LAT + 1; j++) begin
            tick();
            check("irq_rise_latency", 32'(irq), (j == S + LAT + 1) ? 32'h1 : 32'h0);
        end
        rd(ADDR_EDGECAP, 32'h01, "edgecap_bit0");
        wr(ADDR_EDGECAP, 32'h01);
        check("irq_at_w1c_edge", 32'(irq), 32'h1);
        tick();
        check("irq_after_w1c", 32'(irq), 32'h0);
        rd(ADDR_EDGECAP, 32'h0, "edgecap_cleared");

        // Falling-only capture on bit 7.
        wr(ADDR_RISE_EN, 32'h0);
        wr(ADDR_FALL_EN, 32'h80);
        in_port[7] = 1'b1;
        settle();
        rd(ADDR_EDGECAP, 32'h0, "rise7_not_latched");
        in_port[7] = 1'b0;
        settle();
        rd(ADDR_EDGECAP, 32'h80, "fall7_latched");
        check("irq_fall_unmasked", 32'(irq), 32'h0);
        wr(ADDR_EDGECAP, 32'h80);
        rd(ADDR_EDGECAP, 32'h0, "fall7_cleared");
        wr(ADDR_FALL_EN, 32'h0);

        // W1C coinciding with the capturing edge: set wins.
        wr(ADDR_RISE_EN, 32'h02);
        wr(ADDR_IRQ_MASK, 32'h02);
        in_port[1] = 1'b1;
        repeat (S + LAT) tick();
        wr(ADDR_EDGECAP, 32'h02);
        tick();
        check("irq_set_wins", 32'(irq), 32'h1);
        rd(ADDR_EDGECAP, 32'h02, "edgecap_set_wins");
        check("irq_set_wins_hold", 32'(irq), 32'h1);
        wr(ADDR_EDGECAP, 32'h02);
        tick();
        check("irq_cleared_bit1", 32'(irq), 32'h0);

        // Latched edge with mask off, then unmask.
        wr(ADDR_IRQ_MASK, 32'h0);
        wr(ADDR_RISE_EN, 32'h08);
        in_port[3] = 1'b1;
        settle();
        check("irq_masked", 32'(irq), 32'h0);
        rd(ADDR_EDGECAP, 32'h08, "edgecap_bit3");
        wr(ADDR_IRQ_MASK, 32'hFF);
        check("irq_mask_same_cycle", 32'(irq), 32'h0);
        tick();
        check("irq_mask_next_cycle", 32'(irq), 32'h1);
        wr(ADDR_RISE_EN, 32'h0);
        rd(ADDR_EDGECAP, 32'h08, "enable_clear_keeps_cap");
        wr(ADDR_IRQ_MASK, 32'h0);

        // Short glitch rejected by the debounce filter.
        wr(ADDR_RISE_EN, 32'h04);
`ifdef IRQ_PIO_DEBOUNCE_EN
        in_port[2] = 1'b1;
        repeat (D - 1) tick();
        in_port[2] = 1'b0;
        repeat (10) tick();
        rd(ADDR_DATA, 32'h0B, "glitch_data");
        rd(ADDR_EDGECAP, 32'h08, "glitch_edgecap");
`endif

        // Held input on bit 2 reaches DATA at the exact latency.
        address    = ADDR_DATA;
        in_port[2] = 1'b1;
        for (int j = 0; j <= S + LAT; j++) begin
            tick();
            check("hold_data_latency", readdata, (j >= S + LAT) ? 32'h0F : 32'h0B);
        end
        settle();
        rd(ADDR_EDGECAP, 32'h0C, "hold_edgecap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
